addsub_serial: RTL and testbench

Digit-serial WIDTH-bit adder/subtractor built around one 4-bit carry-lookahead slice, processing one nibble per clock, LSB nibble first. It accepts an operand pair through a valid/ready handshake, runs WIDTH/4 compute cycles and holds the result until the consumer accepts it. It sits after the `cla4` datapath as its sequential, two-direction (add and subtract) user, trading latency for area on wide operands.

---
 rtl/addsub_pkg.sv | 24 ++
 rtl/addsub_serial_cla4.sv | 29 ++
 rtl/addsub_serial.sv | 137 +++++++++++++
 tb/tb_addsub_serial.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants for the digit-serial adder/subtractor: FSM encoding,
// slice width and op encoding.
package addsub_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Number of DIGIT_W-wide digits in a WIDTH-bit operand.
   function automatic int digit_count(input int width);
      return width / DIGIT_W;
   endfunction

   // Counter width able to index every digit; never narrower than one bit.
   function automatic int digit_cnt_w(input int width);
      return (digit_count(width) > 1) ? $clog2(digit_count(width)) : 1;
   endfunction

endpackage

// File: rtl/addsub_serial_cla4.sv
// Four-bit carry-lookahead slice: all internal carries are computed directly
// from generate/propagate terms instead of rippling.
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   always_comb begin
      g = a & b;
      p = a ^ b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
      s  = p ^ c[3:0];
      co = c[4];
   end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial WIDTH-bit add/subtract using one cla4 slice, LSB nibble first.
// Define ADDSUB_OVF_EN to add the registered signed-overflow output ovf.
module addsub_serial
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
`ifdef ADDSUB_OVF_EN
   output logic             ovf,
`endif
   output logic             co
);

   localparam int NIB   = digit_count(WIDTH);
   localparam int CNT_W = digit_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             co_q, co_d;
`ifdef ADDSUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic [DIGIT_W-1:0] slice_a;
   logic [DIGIT_W-1:0] slice_b;
   logic [DIGIT_W-1:0] slice_s;
   logic               slice_co;

   // Digit select: b_q already holds ~b for subtract, carry_q seeds the +1.
   assign slice_a = a_q[cnt_q*DIGIT_W +: DIGIT_W];
   assign slice_b = b_q[cnt_q*DIGIT_W +: DIGIT_W];

   cla4 u_cla4 (
      .a  (slice_a),
      .b  (slice_b),
      .ci (carry_q),
      .s  (slice_s),
      .co (slice_co)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      co_d    = co_q;
`ifdef ADDSUB_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = (op == OP_SUB) ? ~b : b;
               carry_d = op;
               cnt_d   = '0;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            s_d[cnt_q*DIGIT_W +: DIGIT_W] = slice_s;
            carry_d = slice_co;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               co_d    = slice_co;
`ifdef ADDSUB_OVF_EN
               // The last digit carries the result MSB.
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                       & (slice_s[DIGIT_W-1] != a_q[WIDTH-1]);
`endif
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         co_q    <= 1'b0;
`ifdef ADDSUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         co_q    <= co_d;
`ifdef ADDSUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign s         = s_q;
   assign co        = co_q;
`ifdef ADDSUB_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_serial.sv
// Directed plus random bench for addsub_serial against an arithmetic model;
// ovf is checked only when ADDSUB_OVF_EN is defined.
`timescale 1ns/1ps
module tb_addsub_serial;

   localparam int WIDTH = 32;
   localparam int NIB   = WIDTH / 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             co;
`ifdef ADDSUB_OVF_EN
   logic             ovf;
`endif

   int total = 0;
   int bad   = 0;

   // Expected results packed as {ovf, co, s}.
   logic [WIDTH+1:0] exp_q[$];

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   addsub_serial #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
`ifdef ADDSUB_OVF_EN
      .ovf       (ovf),
`endif
      .co        (co)
   );

   // Reference: plain wide and signed arithmetic on the whole operands.
   function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                              input logic [WIDTH-1:0] mb,
                                              input logic mop);
      logic [WIDTH:0] wide;
      logic           mco;
      logic           mov;
      longint         sa, sb, sr, smax, smin;
      sa = $signed(ma);
      sb = $signed(mb);
      if (mop) begin
         wide = {1'b0, ma} - {1'b0, mb};
         mco  = (ma >= mb);
         sr   = sa - sb;
      end else begin
         wide = {1'b0, ma} + {1'b0, mb};
         mco  = wide[WIDTH];
         sr   = sa + sb;
      end
      smax = (longint'(1) <<< (WIDTH - 1)) - 1;
      smin = -smax - 1;
      mov  = (sr > smax) || (sr < smin);
      return {mov, mco, wide[WIDTH-1:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_s"}, s, 0);
      check({tag, "_co"}, co, 0);
`ifdef ADDSUB_OVF_EN
      check({tag, "_ovf"}, ovf, 0);
`endif
   endtask

   // driver: one full transaction, holding out_ready low for hold cycles in DONE
   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                         input logic top, input int hold);
      int lat;
      logic [WIDTH+1:0] e;
      lat = 0;
      while (!in_ready && lat < 4 * NIB) begin
         tick();
         lat++;
      end
      check("idle_ready", in_ready, 1);
      a = ta;
      b = tbv;
      op = top;
      in_valid = 1'b1;
      out_ready = (hold == 0);
      exp_q.push_back(model(ta, tbv, top));
      tick();
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      op = ~top;
      check("calc_not_ready", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 3 * NIB) begin
         in_valid = 1'($urandom_range(0, 1));
         tick();
         lat++;
      end
      in_valid = 1'b0;
      check("latency", lat, NIB);
      e = exp_q.pop_front();
      check("s", s, e[WIDTH-1:0]);
      check("co", co, e[WIDTH]);
`ifdef ADDSUB_OVF_EN
      check("ovf", ovf, e[WIDTH+1]);
`endif
      check("done_not_ready", in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         a = $urandom;
         tick();
         check("hold_valid", out_valid, 1);
         check("hold_not_ready", in_ready, 0);
         check("hold_s", s, e[WIDTH-1:0]);
         check("hold_co", co, e[WIDTH]);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("release_valid", out_valid, 0);
      check("release_ready", in_ready, 1);
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      op = 1'b0;
      a = '0;
      b = '0;
      tick();
      tick();
      reset = 1'b0;
      check_reset_outputs("reset");

      // Reset mid-CALC discards the operation.
      a = 32'h0000_FFFF;
      b = 32'h0000_0001;
      op = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_outputs("rst_calc");
      for (int i = 0; i < NIB + 1; i++) tick();
      check("rst_calc_no_result", out_valid, 0);

      // Reset wins over a simultaneous handshake.
      a = 32'h1234_5678;
      b = 32'h1;
      in_valid = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      in_valid = 1'b0;
      check("rst_hs_ready", in_ready, 1);
      for (int i = 0; i < NIB + 1; i++) tick();
      check("rst_hs_no_result", out_valid, 0);

      // Reset while holding a result in DONE.
      a = 32'h0F0F_0F0F;
      b = 32'h0101_0101;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < NIB; i++) tick();
      check("rst_done_valid_before", out_valid, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_outputs("rst_done");

      // Directed arithmetic corners.
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
      run_op(32'h0000_000A, 32'h0000_0006, 1'b1, 2);
      run_op(32'h0000_0005, 32'h0000_000A, 1'b1, 0);
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1);
      run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0);
      run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 5);
      run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
      run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 0);

      // Randomized operands, ops and backpressure.
      for (int n = 0; n < 30; n++) begin
         logic [WIDTH-1:0] ra;
         logic [WIDTH-1:0] rb;
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = ra;
            1: ra = {1'b0, {(WIDTH-1){1'b1}}};
            2: rb = {1'b1, {(WIDTH-1){1'b0}}};
            default: ;
         endcase
         run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
